phase_search_ctrl: RTL and testbench

Receiver-side controller that picks the downsampler phase (o_fase) automatically instead of taking it from the switches. It steps through every oversampling phase and flushes the pipeline after each change. It then counts I+Q slicer errors over a fixed symbol window, locks the phase with the fewest errors, and keeps monitoring that phase, restarting the search if the error rate degrades. It sits between the BER comparators (error inputs) and the dwnsmp instances (phase output).

---
 rtl/phase_search_ctrl_pkg.sv | 19 +
 rtl/phase_search_ctrl_win.sv | 42 ++++
 rtl/phase_search_ctrl.sv | 158 +++++++++++++++
 tb/tb_phase_search_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_search_ctrl_pkg.sv
// Shared definitions for the downsampler phase search controller.
// State encoding and error-counter width derivation.
package phase_search_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE          = 3'd0,
      ST_SETTLE        = 3'd1,
      ST_MEASURE       = 3'd2,
      ST_COMPARE       = 3'd3,
      ST_LOCKED_SETTLE = 3'd4,
      ST_LOCKED        = 3'd5
   } state_t;

   // Two error flags per symbol: a full window can reach 2*2^win_log2.
   function automatic int cnt_width(input int win_log2);
      return win_log2 + 2;
   endfunction

endpackage

// File: rtl/phase_search_ctrl_win.sv
// Window error counter: counts 2^WIN_LOG2 strobes, accumulates I+Q errors.
// done is combinational on the closing strobe; err_total includes that strobe.
module win_err_counter
   import phase_search_ctrl_pkg::*;
#(
   parameter int WIN_LOG2 = 10,
   parameter int CNT_W    = cnt_width(WIN_LOG2)
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             valid,
   input  logic             err_i,
   input  logic             err_q,
   output logic             done,
   output logic [CNT_W-1:0] err_total
);

   logic [WIN_LOG2-1:0] sym_cnt;
   logic [CNT_W-1:0]    err_acc;
   logic [1:0]          inc;

   assign inc       = {1'b0, err_i} + {1'b0, err_q};
   assign err_total = err_acc + CNT_W'(inc);
   assign done      = en && valid && (sym_cnt == '1);

   // The symbol counter wraps on its own, so back-to-back windows need no clear.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         sym_cnt <= '0;
         err_acc <= '0;
      end else if (clr) begin
         sym_cnt <= '0;
         err_acc <= '0;
      end else if (en && valid) begin
         sym_cnt <= sym_cnt + WIN_LOG2'(1);
         err_acc <= done ? '0 : err_total;
      end
   end

endmodule

// File: rtl/phase_search_ctrl.sv
// Automatic downsampler phase search: sweeps all phases, locks the one with
// fewest slicer errors per window, and re-searches if the locked phase degrades.
module phase_search_ctrl
   import phase_search_ctrl_pkg::*;
#(
   parameter int NPHASE   = 4,
   parameter int PH_W     = 2,
   parameter int WIN_LOG2 = 10,
   parameter int SETTLE   = 16,
   parameter int THRESH   = 8,
   parameter int CNT_W    = cnt_width(WIN_LOG2)
) (
   input  logic             clock,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic             i_start,
   input  logic             i_valid,
   input  logic             i_err_i,
   input  logic             i_err_q,
   output logic [PH_W-1:0]  o_fase,
   output logic             o_ber_clr,
   output logic             o_busy,
   output logic             o_locked,
   output logic [CNT_W-1:0] o_best_err,
   output logic [CNT_W-1:0] o_win_err
);

   state_t           state, state_nxt;
   logic [PH_W-1:0]  phase, phase_nxt;
   logic [PH_W-1:0]  best_phase, best_phase_nxt;
   logic [CNT_W-1:0] best, best_nxt;
   logic [CNT_W-1:0] win_err, win_err_nxt;
   logic [7:0]       settle_cnt, settle_cnt_nxt;
   logic             ber_clr, ber_clr_nxt;

   logic             win_en;
   logic             win_done;
   logic [CNT_W-1:0] win_total;
   logic             better;

   // Counter only runs in measuring states; everywhere else it is held clear.
   assign win_en = (state == ST_MEASURE) || (state == ST_LOCKED);
   assign better = (win_err < best);

   win_err_counter #(
      .WIN_LOG2 (WIN_LOG2),
      .CNT_W    (CNT_W)
   ) u_win (
      .clock     (clock),
      .rst_n     (i_reset),
      .clr       (!win_en),
      .en        (win_en),
      .valid     (i_valid),
      .err_i     (i_err_i),
      .err_q     (i_err_q),
      .done      (win_done),
      .err_total (win_total)
   );

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         state      <= ST_IDLE;
         phase      <= '0;
         best_phase <= '0;
         best       <= '1;
         win_err    <= '0;
         settle_cnt <= '0;
         ber_clr    <= 1'b0;
      end else begin
         state      <= state_nxt;
         phase      <= phase_nxt;
         best_phase <= best_phase_nxt;
         best       <= best_nxt;
         win_err    <= win_err_nxt;
         settle_cnt <= settle_cnt_nxt;
         ber_clr    <= ber_clr_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      phase_nxt      = phase;
      best_phase_nxt = best_phase;
      best_nxt       = best;
      win_err_nxt    = win_err;
      settle_cnt_nxt = '0;
      ber_clr_nxt    = 1'b0;

      if (!i_enable) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  state_nxt      = ST_SETTLE;
                  phase_nxt      = '0;
                  best_nxt       = '1;
                  best_phase_nxt = '0;
                  ber_clr_nxt    = 1'b1;
               end
            end
            ST_SETTLE, ST_LOCKED_SETTLE: begin
               settle_cnt_nxt = settle_cnt;
               if (i_valid) begin
                  if (settle_cnt == 8'(SETTLE - 1)) begin
                     settle_cnt_nxt = '0;
                     state_nxt      = (state == ST_SETTLE) ? ST_MEASURE : ST_LOCKED;
                  end else begin
                     settle_cnt_nxt = settle_cnt + 8'd1;
                  end
               end
            end
            ST_MEASURE: begin
               if (win_done) begin
                  win_err_nxt = win_total;
                  state_nxt   = ST_COMPARE;
               end
            end
            ST_COMPARE: begin
               if (better) begin
                  best_nxt       = win_err;
                  best_phase_nxt = phase;
               end
               ber_clr_nxt = 1'b1;
               if (phase != PH_W'(NPHASE - 1)) begin
                  phase_nxt = phase + PH_W'(1);
                  state_nxt = ST_SETTLE;
               end else begin
                  // The last phase's own result must be considered for the lock.
                  phase_nxt = better ? phase : best_phase;
                  state_nxt = ST_LOCKED_SETTLE;
               end
            end
            ST_LOCKED: begin
               if (win_done) begin
                  win_err_nxt = win_total;
                  if (win_total > CNT_W'(THRESH)) begin
                     state_nxt      = ST_SETTLE;
                     phase_nxt      = '0;
                     best_nxt       = '1;
                     best_phase_nxt = '0;
                     ber_clr_nxt    = 1'b1;
                  end
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign o_fase     = phase;
   assign o_ber_clr  = ber_clr;
   assign o_busy     = (state == ST_SETTLE) || (state == ST_MEASURE) || (state == ST_COMPARE);
   assign o_locked   = (state == ST_LOCKED);
   assign o_best_err = best;
   assign o_win_err  = win_err;

endmodule

// File: tb/tb_phase_search_ctrl.sv
// Bench for phase_search_ctrl: random error patterns per phase, scored against
// a per-phase error tally and a first-minimum selection.
module tb_phase_search_ctrl;

   localparam int NPHASE   = 4;
   localparam int PH_W     = 2;
   localparam int WIN_LOG2 = 4;
   localparam int SETTLE   = 4;
   localparam int THRESH   = 2;
   localparam int CNT_W    = WIN_LOG2 + 2;
   localparam int WIN      = 1 << WIN_LOG2;
   localparam int ALL_ONES = (1 << CNT_W) - 1;

   logic             clock;
   logic             i_reset, i_enable, i_start, i_valid, i_err_i, i_err_q;
   logic [PH_W-1:0]  o_fase;
   logic             o_ber_clr, o_busy, o_locked;
   logic [CNT_W-1:0] o_best_err, o_win_err;

   int n_chk  = 0;
   int n_fail = 0;
   int ber_cnt = 0;
   int ber_base;
   int cnt [NPHASE];
   int s;

   phase_search_ctrl #(
      .NPHASE(NPHASE), .PH_W(PH_W), .WIN_LOG2(WIN_LOG2),
      .SETTLE(SETTLE), .THRESH(THRESH), .CNT_W(CNT_W)
   ) dut (
      .clock      (clock),
      .i_reset    (i_reset),
      .i_enable   (i_enable),
      .i_start    (i_start),
      .i_valid    (i_valid),
      .i_err_i    (i_err_i),
      .i_err_q    (i_err_q),
      .o_fase     (o_fase),
      .o_ber_clr  (o_ber_clr),
      .o_busy     (o_busy),
      .o_locked   (o_locked),
      .o_best_err (o_best_err),
      .o_win_err  (o_win_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) if (o_ber_clr === 1'b1) ber_cnt++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic strobe_hi(input logic ei, input logic eq);
      @(negedge clock);
      i_valid = 1'b1; i_err_i = ei; i_err_q = eq;
      @(negedge clock);
      i_valid = 1'b0;
      i_err_i = 1'($urandom_range(1, 0));
      i_err_q = 1'($urandom_range(1, 0));
   endtask

   task automatic gap();
      repeat (2) @(negedge clock);
   endtask

   task automatic strobe(input logic ei, input logic eq);
      strobe_hi(ei, eq);
      gap();
   endtask

   // target < 0: free random errors; otherwise exactly target errors spread randomly.
   task automatic meas_window(input int target, input bit tail_gap, output int sum);
      int r, add, lo, hi;
      logic ei, eq;
      sum = 0;
      r = target;
      for (int k = 0; k < WIN; k++) begin
         if (target < 0) begin
            ei = ($urandom_range(3, 0) == 0);
            eq = ($urandom_range(3, 0) == 0);
         end else begin
            lo = r - 2 * (WIN - 1 - k);
            if (lo < 0) lo = 0;
            hi = (r < 2) ? r : 2;
            add = $urandom_range(hi, lo);
            ei = (add == 2) || (add == 1 && $urandom_range(1, 0) == 1);
            eq = (add == 2) || (add == 1 && !ei);
            r -= add;
         end
         sum += int'(ei) + int'(eq);
         strobe_hi(ei, eq);
         if (k < WIN - 1 || tail_gap) gap();
      end
   endtask

   task automatic start_search(input string tag);
      @(negedge clock);
      ber_base = ber_cnt;
      i_enable = 1'b1; i_start = 1'b1;
      @(negedge clock);
      i_start = 1'b0;
      chk({tag, "_start_ber_clr"}, 32'(o_ber_clr), 1);
      chk({tag, "_start_busy"}, 32'(o_busy), 1);
      chk({tag, "_start_fase"}, 32'(o_fase), 0);
      chk({tag, "_start_best"}, 32'(o_best_err), ALL_ONES);
   endtask

   // mode 0 random, 1 errors everywhere but phase 2, 2 three per window, 3 settle-only errors
   task automatic run_search(input int mode);
      int t, sm;
      for (int p = 0; p < NPHASE; p++) begin
         for (int k = 0; k < SETTLE; k++) begin
            if (mode == 3) strobe(1'b1, 1'b1);
            else strobe(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
         end
         case (mode)
            1:       t = (p == 2) ? 0 : WIN;
            2:       t = 3;
            3:       t = 0;
            default: t = -1;
         endcase
         meas_window(t, 1'b1, sm);
         cnt[p] = sm;
      end
      for (int k = 0; k < SETTLE; k++)
         strobe(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
   endtask

   task automatic check_lock(input string tag);
      int bv, bp;
      bv = cnt[0]; bp = 0;
      for (int p = 1; p < NPHASE; p++)
         if (cnt[p] < bv) begin bv = cnt[p]; bp = p; end
      chk({tag, "_locked"}, 32'(o_locked), 1);
      chk({tag, "_busy"}, 32'(o_busy), 0);
      chk({tag, "_fase"}, 32'(o_fase), bp);
      chk({tag, "_best"}, 32'(o_best_err), bv);
      chk({tag, "_win"}, 32'(o_win_err), cnt[NPHASE-1]);
      chk({tag, "_ber_pulses"}, 32'(ber_cnt - ber_base), NPHASE + 1);
   endtask

   initial begin
      i_reset = 1'b0; i_enable = 1'b0; i_start = 1'b0;
      i_valid = 1'b0; i_err_i = 1'b0; i_err_q = 1'b0;

      // Reset held against random inputs
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         i_enable = 1'($urandom_range(1, 0));
         i_start  = 1'($urandom_range(1, 0));
         i_valid  = 1'($urandom_range(1, 0));
         i_err_i  = 1'($urandom_range(1, 0));
         i_err_q  = 1'($urandom_range(1, 0));
         #1;
         chk("rst_fase", 32'(o_fase), 0);
         chk("rst_locked", 32'(o_locked), 0);
         chk("rst_busy", 32'(o_busy), 0);
         chk("rst_best", 32'(o_best_err), ALL_ONES);
         chk("rst_ber_clr", 32'(o_ber_clr), 0);
         chk("rst_win", 32'(o_win_err), 0);
      end
      @(negedge clock);
      i_reset = 1'b1; i_enable = 1'b1; i_start = 1'b0; i_valid = 1'b0;

      // Start while disabled: IDLE wins
      @(negedge clock);
      i_enable = 1'b0; i_start = 1'b1;
      @(negedge clock);
      i_start = 1'b0;
      chk("dis_start_busy", 32'(o_busy), 0);
      chk("dis_start_ber_clr", 32'(o_ber_clr), 0);

      // Only phase 2 is clean
      start_search("t2");
      run_search(1);
      check_lock("t2");
      chk("t2_fase_is_2", 32'(o_fase), 2);

      // Locked monitoring: 2 errors stays, 3 errors forces a re-search
      meas_window(2, 1'b1, s);
      chk("t5_win2", 32'(o_win_err), s);
      chk("t5_stay_locked", 32'(o_locked), 1);
      chk("t5_stay_fase", 32'(o_fase), 2);
      meas_window(3, 1'b0, s);
      chk("t5_win3", 32'(o_win_err), s);
      chk("t5_unlock", 32'(o_locked), 0);
      chk("t5_ber_clr", 32'(o_ber_clr), 1);
      chk("t5_fase0", 32'(o_fase), 0);
      chk("t5_busy", 32'(o_busy), 1);
      chk("t5_best_reset", 32'(o_best_err), ALL_ONES);
      gap();
      @(negedge clock);
      i_enable = 1'b0;
      @(negedge clock);
      chk("t5_idle_busy", 32'(o_busy), 0);

      // Equal error counts everywhere: first phase wins
      start_search("t3");
      run_search(2);
      check_lock("t3");
      chk("t3_best_is_3", 32'(o_best_err), 3);
      @(negedge clock); i_enable = 1'b0;

      // Errors only during settle are ignored
      start_search("t4");
      run_search(3);
      check_lock("t4");
      @(negedge clock); i_enable = 1'b0;

      // Random error patterns
      for (int r = 0; r < 3; r++) begin
         start_search("rnd");
         run_search(0);
         check_lock("rnd");
         @(negedge clock); i_enable = 1'b0;
      end

      // Disable mid-measure on phase 1
      start_search("t6");
      for (int k = 0; k < SETTLE; k++) strobe(1'b0, 1'b0);
      meas_window(-1, 1'b1, s);
      cnt[0] = s;
      for (int k = 0; k < SETTLE; k++) strobe(1'b0, 1'b0);
      for (int k = 0; k < 5; k++) strobe(1'b1, 1'b0);
      @(negedge clock);
      i_enable = 1'b0;
      @(negedge clock);
      chk("t6_busy", 32'(o_busy), 0);
      chk("t6_locked", 32'(o_locked), 0);
      chk("t6_fase_hold", 32'(o_fase), 1);
      chk("t6_win_hold", 32'(o_win_err), cnt[0]);
      chk("t6_best_hold", 32'(o_best_err), cnt[0]);
      start_search("t6r");

      // Async reset between edges during phase 1
      for (int k = 0; k < SETTLE; k++) strobe(1'b0, 1'b0);
      meas_window(-1, 1'b1, s);
      for (int k = 0; k < SETTLE; k++) strobe(1'b0, 1'b0);
      strobe(1'b1, 1'b1);
      chk("ar_pre_fase", 32'(o_fase), 1);
      @(negedge clock);
      #2 i_reset = 1'b0;
      #1;
      chk("ar_fase", 32'(o_fase), 0);
      chk("ar_busy", 32'(o_busy), 0);
      chk("ar_best", 32'(o_best_err), ALL_ONES);
      chk("ar_win", 32'(o_win_err), 0);
      @(negedge clock);
      i_reset = 1'b1;
      start_search("ar_restart");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
